// File: rtl/dilithium_low_res_pkg.sv
// Shared definitions for the low-resource Dilithium command interface:
// opcodes, payload types, default transfer sizes and the responder state set.
package dilithium_low_res_pkg;

   localparam logic [3:0] OP_NOP          = 4'b0000;
   localparam logic [3:0] OP_DIGEST       = 4'b0001;
   localparam logic [3:0] OP_SIGN         = 4'b0010;
   localparam logic [3:0] OP_SIGN_PRECOMP = 4'b0011;
   localparam logic [3:0] OP_VRFY         = 4'b0100;
   localparam logic [3:0] OP_VRFY_PRECOMP = 4'b0101;
   localparam logic [3:0] OP_KGEN         = 4'b0111;

   localparam logic [1:0] OP_CLASS_STOR = 2'b11;
   localparam logic [1:0] OP_CLASS_LOAD = 2'b10;

   localparam logic [1:0] PT_PK   = 2'b00;
   localparam logic [1:0] PT_SK   = 2'b01;
   localparam logic [1:0] PT_SIG  = 2'b10;
   localparam logic [1:0] PT_SEED = 2'b11;

   localparam int PK_WORDS_DEF   = 328;
   localparam int SK_WORDS_DEF   = 640;
   localparam int SIG_WORDS_DEF  = 605;
   localparam int SEED_WORDS_DEF = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_STOR    = 3'd1,
      ST_LD_RD   = 3'd2,
      ST_LD_WAIT = 3'd3,
      ST_LD_OUT  = 3'd4,
      ST_EXEC    = 3'd5
   } state_t;

   function automatic logic is_exec_op(input logic [3:0] op);
      case (op)
         OP_DIGEST, OP_SIGN, OP_SIGN_PRECOMP,
         OP_VRFY, OP_VRFY_PRECOMP, OP_KGEN: is_exec_op = 1'b1;
         default:                           is_exec_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/op_responder_low_res.sv
// Command responder: decodes initiator opcodes, streams payloads into and out of
// the payload memory, and launches the compute engine for execution opcodes.
module op_responder_low_res
   import dilithium_low_res_pkg::*;
#(
   parameter int PK_WORDS   = PK_WORDS_DEF,
   parameter int SK_WORDS   = SK_WORDS_DEF,
   parameter int SIG_WORDS  = SIG_WORDS_DEF,
   parameter int SEED_WORDS = SEED_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  op_in,
   input  logic        op_valid_in,
   output logic        ready_out,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_rcv_out,
   output logic [31:0] data_out,
   output logic        valid_out,
   input  logic        ready_rcv_in,
   output logic        mem_we,
   output logic        mem_re,
   output logic [11:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        eng_start,
   output logic [3:0]  eng_op,
   input  logic        eng_done,
   output logic        op_error
);

   state_t      state_r, state_next_s;
   logic [9:0]  offset_r, offset_next_s;
   logic [1:0]  type_r, type_next_s;
   logic        accept_s, exec_s, illegal_s, stor_hs_s, last_s;
   logic        ready_rcv_r, valid_out_r, mem_we_r, mem_re_r;
   logic        eng_start_r, op_error_r;
   logic [31:0] data_out_r, mem_wdata_r;
   logic [11:0] mem_addr_r;
   logic [3:0]  eng_op_r;

   function automatic logic [9:0] last_offset(input logic [1:0] ptype);
      case (ptype)
         PT_PK:   last_offset = 10'(PK_WORDS - 1);
         PT_SK:   last_offset = 10'(SK_WORDS - 1);
         PT_SIG:  last_offset = 10'(SIG_WORDS - 1);
         default: last_offset = 10'(SEED_WORDS - 1);
      endcase
   endfunction

   assign last_s = (offset_r == last_offset(type_r));

   // Next-state, offset and command-decode logic
   always_comb begin
      state_next_s  = state_r;
      offset_next_s = offset_r;
      type_next_s   = type_r;
      accept_s      = 1'b0;
      exec_s        = 1'b0;
      illegal_s     = 1'b0;
      stor_hs_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (op_valid_in) begin
               accept_s      = 1'b1;
               offset_next_s = 10'd0;
               type_next_s   = op_in[1:0];
               if (op_in[3:2] == OP_CLASS_STOR) begin
                  state_next_s = ST_STOR;
               end else if (op_in[3:2] == OP_CLASS_LOAD) begin
                  state_next_s = ST_LD_RD;
               end else if (is_exec_op(op_in)) begin
                  exec_s       = 1'b1;
                  state_next_s = ST_EXEC;
               end else if (op_in == OP_NOP) begin
                  state_next_s = ST_IDLE;
               end else begin
                  illegal_s    = 1'b1;
                  state_next_s = ST_IDLE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_STOR: begin
            if (valid_in && ready_rcv_r) begin
               stor_hs_s = 1'b1;
               if (last_s) begin
                  state_next_s = ST_IDLE;
               end else begin
                  offset_next_s = offset_r + 10'd1;
               end
            end else begin
               stor_hs_s = 1'b0;
            end
         end
         ST_LD_RD:   state_next_s = ST_LD_WAIT;
         ST_LD_WAIT: state_next_s = ST_LD_OUT;
         ST_LD_OUT: begin
            if (ready_rcv_in) begin
               if (last_s) begin
                  state_next_s = ST_IDLE;
               end else begin
                  offset_next_s = offset_r + 10'd1;
                  state_next_s  = ST_LD_RD;
               end
            end else begin
               state_next_s = ST_LD_OUT;
            end
         end
         ST_EXEC: begin
            // a done pulse in the launch cycle belongs to no command of ours
            if (eng_done && !eng_start_r) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_EXEC;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // State, counters and registered interface outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         offset_r    <= 10'd0;
         type_r      <= 2'd0;
         ready_rcv_r <= 1'b0;
         valid_out_r <= 1'b0;
         data_out_r  <= 32'd0;
         mem_we_r    <= 1'b0;
         mem_re_r    <= 1'b0;
         mem_addr_r  <= 12'd0;
         mem_wdata_r <= 32'd0;
         eng_start_r <= 1'b0;
         eng_op_r    <= 4'd0;
         op_error_r  <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         offset_r    <= offset_next_s;
         type_r      <= type_next_s;
         ready_rcv_r <= (state_next_s == ST_STOR);
         valid_out_r <= (state_next_s == ST_LD_OUT);
         mem_re_r    <= (state_next_s == ST_LD_RD);
         mem_we_r    <= stor_hs_s;
         eng_start_r <= accept_s && exec_s;
         op_error_r  <= accept_s && illegal_s;
         if (stor_hs_s) begin
            mem_addr_r  <= {type_r, offset_r};
            mem_wdata_r <= data_in;
         end else if (state_next_s == ST_LD_RD) begin
            mem_addr_r  <= {type_next_s, offset_next_s};
         end
         if (state_r == ST_LD_WAIT) begin
            data_out_r <= mem_rdata;
         end
         if (accept_s && exec_s) begin
            eng_op_r <= op_in;
         end
      end
   end

   assign ready_out     = (state_r == ST_IDLE);
   assign ready_rcv_out = ready_rcv_r;
   assign valid_out     = valid_out_r;
   assign data_out      = data_out_r;
   assign mem_we        = mem_we_r;
   assign mem_re        = mem_re_r;
   assign mem_addr      = mem_addr_r;
   assign mem_wdata     = mem_wdata_r;
   assign eng_start     = eng_start_r;
   assign eng_op        = eng_op_r;
   assign op_error      = op_error_r;

endmodule

// File: tb/tb_op_responder_low_res.sv
// Randomized self-checking bench for op_responder_low_res with a payload-memory
// model and a transaction-level reference of expected writes, reads and launches.
module tb_op_responder_low_res;
   import dilithium_low_res_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  op_in = 4'd0;
   logic        op_valid_in = 1'b0;
   logic        ready_out;
   logic [31:0] data_in = 32'd0;
   logic        valid_in = 1'b0;
   logic        ready_rcv_out;
   logic [31:0] data_out;
   logic        valid_out;
   logic        ready_rcv_in = 1'b0;
   logic        mem_we, mem_re;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = 32'd0;
   logic        eng_start;
   logic [3:0]  eng_op;
   logic        eng_done = 1'b0;
   logic        op_error;

   op_responder_low_res dut (
      .clk(clk), .rst(rst), .op_in(op_in), .op_valid_in(op_valid_in), .ready_out(ready_out),
      .data_in(data_in), .valid_in(valid_in), .ready_rcv_out(ready_rcv_out),
      .data_out(data_out), .valid_out(valid_out), .ready_rcv_in(ready_rcv_in),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .eng_start(eng_start), .eng_op(eng_op), .eng_done(eng_done),
      .op_error(op_error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] ram     [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic        init_ram = 1'b0;

   logic [43:0] exp_wr_q[$];
   logic [11:0] exp_ra_q[$];
   logic [31:0] exp_rd_q[$];
   logic [3:0]  exp_op_q[$];
   int          exp_err = 0;
   logic [11:0] wr_log[$];
   logic [11:0] ra_log[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int words_of(input logic [1:0] t);
      case (t)
         PT_PK:   return 328;
         PT_SK:   return 640;
         PT_SIG:  return 605;
         default: return 8;
      endcase
   endfunction

   // payload memory: one-cycle read latency
   always @(posedge clk) begin
      if (init_ram) begin
         for (int i = 0; i < 4096; i++) ram[i] <= ref_mem[i];
      end
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   // compare process: every strobe and output word against the reference queues
   initial begin
      logic        prev_stall;
      logic [31:0] prev_data;
      logic [43:0] w;
      prev_stall = 1'b0;
      prev_data  = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("reset_quiet", {59'd0, mem_we, mem_re, eng_start, valid_out, op_error}, 64'd0);
            prev_stall = 1'b0;
         end else begin
            if (mem_we) begin
               chk("write_expected", exp_wr_q.size() == 0, 0);
               if (exp_wr_q.size() > 0) begin
                  w = exp_wr_q.pop_front();
                  chk("wr_addr", mem_addr, w[43:32]);
                  chk("wr_data", mem_wdata, w[31:0]);
               end
               wr_log.push_back(mem_addr);
            end
            if (mem_re) begin
               chk("read_expected", exp_ra_q.size() == 0, 0);
               if (exp_ra_q.size() > 0) chk("rd_addr", mem_addr, exp_ra_q.pop_front());
               ra_log.push_back(mem_addr);
            end
            if (prev_stall) begin
               chk("valid_held", valid_out, 1);
               chk("data_stable", data_out, prev_data);
            end
            if (valid_out && ready_rcv_in) begin
               chk("out_expected", exp_rd_q.size() == 0, 0);
               if (exp_rd_q.size() > 0) chk("out_data", data_out, exp_rd_q.pop_front());
            end
            prev_stall = valid_out && !ready_rcv_in;
            prev_data  = data_out;
            if (eng_start) begin
               chk("start_expected", exp_op_q.size() == 0, 0);
               if (exp_op_q.size() > 0) chk("eng_op", eng_op, exp_op_q.pop_front());
            end
            if (op_error) begin
               chk("op_error_expected", exp_err > 0, 1);
               if (exp_err > 0) exp_err--;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [3:0] op);
      int n = 0;
      while (!ready_out && n < 5000) begin
         tick();
         n++;
      end
      chk("ready_before_cmd", ready_out, 1);
      op_in       = op;
      op_valid_in = 1'b1;
      tick();
      op_valid_in = 1'b0;
      op_in       = 4'($urandom);
   endtask

   task automatic do_stor(input logic [1:0] t, input bit seq_data, input bit inject);
      int          n = words_of(t);
      logic [31:0] d;
      logic [11:0] a;
      bit          hs;
      int          guard;
      wr_log.delete();
      send_cmd({OP_CLASS_STOR, t});
      chk("stor_busy", ready_out, 0);
      for (int i = 0; i < n; i++) begin
         d = seq_data ? 32'(i + 1) : $urandom;
         a = {t, 10'(i)};
         exp_wr_q.push_back({a, d});
         ref_mem[a] = d;
         if (!seq_data) begin
            while ($urandom_range(0, 3) == 0) begin
               valid_in = 1'b0;
               tick();
            end
         end
         valid_in = 1'b1;
         data_in  = d;
         if (inject && i == 3) begin
            op_in       = OP_VRFY;
            op_valid_in = 1'b1;
         end
         guard = 0;
         hs    = 1'b0;
         while (!hs && guard < 100) begin
            hs = ready_rcv_out;
            tick();
            guard++;
         end
         chk("stor_handshake", hs, 1);
         if (inject && i == 5) op_valid_in = 1'b0;
      end
      valid_in = 1'b0;
      chk("stor_ready_after_last", ready_out, 1);
      tick();
      chk("stor_write_count", wr_log.size(), n);
   endtask

   task automatic do_load(input logic [1:0] t, input int mode, input int abort_at);
      int n = words_of(t);
      int guard = 0;
      bit aborted = 1'b0;
      ra_log.delete();
      for (int i = 0; i < n; i++) begin
         exp_ra_q.push_back({t, 10'(i)});
         exp_rd_q.push_back(ref_mem[{t, 10'(i)}]);
      end
      ready_rcv_in = 1'b0;
      send_cmd({OP_CLASS_LOAD, t});
      chk("load_busy", ready_out, 0);
      while (exp_rd_q.size() > 0 && guard < n * 8 + 20 && !aborted) begin
         if (abort_at > 0 && (n - exp_rd_q.size()) >= abort_at && valid_out) begin
            rst = 1'b1;
            #1;
            chk("abort_valid_out", valid_out, 0);
            chk("abort_ready_out", ready_out, 1);
            chk("abort_data_out", data_out, 0);
            exp_ra_q.delete();
            exp_rd_q.delete();
            tick();
            tick();
            rst     = 1'b0;
            aborted = 1'b1;
         end else begin
            ready_rcv_in = (mode == 0) ? ~ready_rcv_in : 1'($urandom_range(0, 1));
            tick();
            guard++;
         end
      end
      chk("load_aborted", aborted, abort_at > 0);
      if (!aborted) begin
         chk("load_drained", exp_rd_q.size(), 0);
         chk("load_ready_after_last", ready_out, 1);
         chk("load_read_count", ra_log.size(), n);
      end
      ready_rcv_in = 1'b0;
      repeat (4) tick();
      chk("idle_after_load", ready_out, 1);
   endtask

   task automatic do_exec(input logic [3:0] op, input int delay);
      exp_op_q.push_back(op);
      send_cmd(op);
      chk("eng_start_pulse", eng_start, 1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("early_done_ignored", ready_out, 0);
      chk("eng_start_single", eng_start, 0);
      repeat (delay) tick();
      chk("exec_busy", ready_out, 0);
      chk("eng_op_held", eng_op, op);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("exec_idle_after_done", ready_out, 1);
   endtask

   task automatic do_illegal();
      exp_err++;
      send_cmd(4'b0110);
      chk("illegal_ready", ready_out, 1);
      tick();
      tick();
      chk("illegal_err_seen", exp_err, 0);
      chk("illegal_still_idle", ready_out, 1);
   endtask

   task automatic do_nop();
      send_cmd(OP_NOP);
      chk("nop_idle", ready_out, 1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("idle_done_ignored", ready_out, 1);
   endtask

   initial begin
      #900000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] ex_ops [6];
      ex_ops = '{OP_DIGEST, OP_SIGN, OP_SIGN_PRECOMP, OP_VRFY, OP_VRFY_PRECOMP, OP_KGEN};
      for (int i = 0; i < 4096; i++) ref_mem[i] = $urandom;
      init_ram = 1'b1;
      tick();
      init_ram = 1'b0;
      tick();
      chk("rst_ready_out", ready_out, 1);
      chk("rst_ready_rcv_out", ready_rcv_out, 0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_op", eng_op, 0);
      chk("rst_op_error", op_error, 0);
      rst = 1'b0;
      tick();

      do_stor(PT_SEED, 1'b1, 1'b1);
      chk("seed_first_addr", wr_log[0], 12'hC00);
      chk("seed_last_addr", wr_log[7], 12'hC07);
      chk("seed_model_pin", ref_mem[12'hC03], 32'd4);
      do_load(PT_SEED, 0, 0);

      do_load(PT_SK, 0, 0);
      chk("sk_first_addr", ra_log[0], 12'h400);
      chk("sk_last_addr", ra_log[639], 12'h67F);

      do_exec(OP_KGEN, 50);
      do_illegal();
      do_nop();
      do_load(PT_PK, 1, 100);
      chk("after_abort_ready", ready_out, 1);

      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 4))
            0:       do_stor(2'($urandom), 1'b0, 1'($urandom));
            1:       do_load(2'($urandom), int'($urandom_range(0, 1)), 0);
            2:       do_exec(ex_ops[$urandom_range(0, 5)], int'($urandom_range(1, 20)));
            3:       do_illegal();
            default: do_nop();
         endcase
      end

      repeat (5) tick();
      chk("final_wr_q_empty", exp_wr_q.size(), 0);
      chk("final_ra_q_empty", exp_ra_q.size(), 0);
      chk("final_rd_q_empty", exp_rd_q.size(), 0);
      chk("final_op_q_empty", exp_op_q.size(), 0);
      chk("final_err_empty", exp_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
